// File: rtl/control_word_sequencer.sv
// Fetch/execute sequencer: owns PC, IR, micro-state and NZCV, and turns the decoders'
// control word into gated datapath strobes and PC updates.
module control_word_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MAX_STEPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    input  logic [30:0] controlWord,
    input  logic [1:0]  nextState,
    input  logic [63:0] K,
    input  logic [3:0]  status_in,
    input  logic [63:0] reg_a,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [31:0] instruction,
    output logic [1:0]  state,
    output logic [3:0]  status,
    output logic [4:0]  DA,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  Fsel,
    output logic        regW,
    output logic        ramW,
    output logic        EN_MEM,
    output logic        EN_ALU,
    output logic        EN_B,
    output logic        EN_PC,
    output logic        Bsel,
    output logic        exec,
    output logic        fault
);

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       regw;
        logic       ramw;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } cw_t;

    typedef enum logic {FETCH, EXEC} fsm_t;

    localparam logic [1:0] LAST_STEP = 2'(MAX_STEPS - 1);

    cw_t         cw;
    fsm_t        fsm, fsm_nxt;
    logic [63:0] pc, pc_nxt;
    logic [31:0] ir, ir_nxt;
    logic [1:0]  st, st_nxt;
    logic [3:0]  nzcv, nzcv_nxt;
    logic [1:0]  step, step_nxt;
    logic        fault_q, fault_nxt;
    logic [63:0] pc_seq, tgt;

    assign cw = controlWord;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm     <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            st      <= '0;
            nzcv    <= '0;
            step    <= '0;
            fault_q <= 1'b0;
        end else begin
            fsm     <= fsm_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            st      <= st_nxt;
            nzcv    <= nzcv_nxt;
            step    <= step_nxt;
            fault_q <= fault_nxt;
        end
    end

    assign pc_seq = pc + 64'd4;
    assign tgt    = cw.pcsel ? K : reg_a;

    always_comb begin
        fsm_nxt   = fsm;
        pc_nxt    = pc;
        ir_nxt    = ir;
        st_nxt    = st;
        nzcv_nxt  = nzcv;
        step_nxt  = step;
        fault_nxt = 1'b0;
        case (fsm)
            FETCH: begin
                if (imem_ack) begin
                    ir_nxt   = imem_data;
                    st_nxt   = '0;
                    step_nxt = '0;
                    fsm_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (cw.sl) nzcv_nxt = status_in;
                case (cw.psel)
                    2'b01:   pc_nxt = pc_seq;
                    2'b10:   pc_nxt = tgt;
                    2'b11:   pc_nxt = pc_seq + (tgt << 2);
                    default: pc_nxt = pc;
                endcase
                st_nxt = nextState;
                if (nextState == 2'd0) begin
                    fsm_nxt = FETCH;
                end else if (step == LAST_STEP) begin
                    // runaway micro-sequence: skip the instruction and flag it
                    fsm_nxt   = FETCH;
                    st_nxt    = '0;
                    pc_nxt    = pc_seq;
                    fault_nxt = 1'b1;
                end else begin
                    step_nxt = step + 2'd1;
                end
            end
            default: fsm_nxt = FETCH;
        endcase
    end

    assign exec        = (fsm == EXEC);
    assign imem_req    = (fsm == FETCH);
    assign imem_addr   = pc;
    assign instruction = ir;
    assign state       = st;
    assign status      = nzcv;
    assign fault       = fault_q;

    assign DA     = cw.da;
    assign SA     = cw.sa;
    assign SB     = cw.sb;
    assign Fsel   = cw.fsel;
    assign Bsel   = cw.bsel;
    assign regW   = cw.regw   & exec;
    assign ramW   = cw.ramw   & exec;
    assign EN_MEM = cw.en_mem & exec;
    assign EN_ALU = cw.en_alu & exec;
    assign EN_B   = cw.en_b   & exec;
    assign EN_PC  = cw.en_pc  & exec;

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed bench for control_word_sequencer: fetch handshake, PC select modes,
// status latch, strobe gating, step-limit abort and reset mid-instruction.
module tb_control_word_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic [30:0] controlWord;
    logic [1:0]  nextState;
    logic [63:0] K;
    logic [3:0]  status_in;
    logic [63:0] reg_a;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [3:0]  status;
    logic [4:0]  DA, SA, SB, Fsel;
    logic        regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, exec, fault;

    int vectors     = 0;
    int miscompares = 0;

    control_word_sequencer dut (
        .clock(clock), .reset(reset), .imem_data(imem_data), .imem_ack(imem_ack),
        .controlWord(controlWord), .nextState(nextState), .K(K), .status_in(status_in),
        .reg_a(reg_a), .imem_req(imem_req), .imem_addr(imem_addr), .instruction(instruction),
        .state(state), .status(status), .DA(DA), .SA(SA), .SB(SB), .Fsel(Fsel),
        .regW(regW), .ramW(ramW), .EN_MEM(EN_MEM), .EN_ALU(EN_ALU), .EN_B(EN_B),
        .EN_PC(EN_PC), .Bsel(Bsel), .exec(exec), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {Psel, DA/SA/SB/Fsel = 0, {regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC}, Bsel=0, PCsel, SL}
    function automatic logic [30:0] mk(input logic [1:0] psel, input logic [5:0] strb,
                                       input logic pcsel, input logic sl);
        return {psel, 20'd0, strb, 1'b0, pcsel, sl};
    endfunction

    task automatic fetch(input logic [31:0] word);
        imem_data = word;
        imem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
    endtask

    task automatic exec1(input logic [30:0] cwv, input logic [63:0] kv, input logic [63:0] ra,
                         input logic [3:0] st_in, input logic [1:0] ns);
        controlWord = cwv;
        K           = kv;
        reg_a       = ra;
        status_in   = st_in;
        nextState   = ns;
        tick();
    endtask

    logic [30:0] cwv;

    initial begin
        reset = 1'b1; imem_data = '0; imem_ack = 1'b0; controlWord = '0;
        nextState = '0; K = '0; status_in = '0; reg_a = '0;
        tick(); tick();
        check("rst_pc", imem_addr, 64'h0);
        check("rst_req", imem_req, 1'b1);
        check("rst_exec", exec, 1'b0);
        check("rst_ir", instruction, 32'h0);
        check("rst_state", state, 2'd0);
        check("rst_status", status, 4'd0);
        check("rst_fault", fault, 1'b0);
        reset = 1'b0;

        // CBZ X3,+4 fetched at address 0, not taken
        imem_data = 32'hB400_0023;
        imem_ack  = 1'b1;
        #1;
        check("fetch_addr", imem_addr, 64'h0);
        tick();
        imem_ack = 1'b0;
        cwv = mk(2'b01, 6'b000010, 1'b0, 1'b0);
        cwv[23:19] = 5'd3;
        controlWord = cwv; nextState = 2'd0;
        #1;
        check("cbz_ir", instruction, 32'hB400_0023);
        check("cbz_exec", exec, 1'b1);
        check("cbz_regW", regW, 1'b0);
        check("cbz_ramW", ramW, 1'b0);
        check("cbz_SA", SA, 5'd3);
        check("cbz_EN_B", EN_B, 1'b1);
        tick();
        check("cbz_pc", imem_addr, 64'h4);
        check("cbz_fetch", imem_req, 1'b1);
        check("fetch_EN_B_gated", EN_B, 1'b0);

        fetch(32'h1);
        exec1(mk(2'b10, 6'd0, 1'b1, 1'b0), 64'h100, 64'h0, 4'd0, 2'd0);
        check("jmp_k", imem_addr, 64'h100);

        fetch(32'h2);
        exec1(mk(2'b11, 6'd0, 1'b1, 1'b0), 64'h4, 64'h0, 4'd0, 2'd0);
        check("cbz_taken", imem_addr, 64'h114);

        fetch(32'h3);
        exec1(mk(2'b10, 6'd0, 1'b1, 1'b0), 64'h100, 64'h0, 4'd0, 2'd0);
        fetch(32'h4);
        exec1(mk(2'b01, 6'd0, 1'b0, 1'b0), 64'h4, 64'h0, 4'd0, 2'd0);
        check("seq_pc", imem_addr, 64'h104);

        fetch(32'h5);
        exec1(mk(2'b10, 6'd0, 1'b0, 1'b0), 64'h55, 64'h2000, 4'd0, 2'd0);
        check("br_reg", imem_addr, 64'h2000);

        fetch(32'h6);
        exec1(mk(2'b10, 6'd0, 1'b1, 1'b0), 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'd0, 2'd0);
        fetch(32'h7);
        exec1(mk(2'b01, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'd0, 2'd0);
        check("pc_wrap", imem_addr, 64'h0);

        // status latch with all strobes requested
        fetch(32'h8);
        controlWord = mk(2'b01, 6'b111111, 1'b0, 1'b1);
        status_in = 4'b0010; nextState = 2'd0;
        #1;
        check("strb_exec", {regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC}, 6'b111111);
        tick();
        check("sl_status", status, 4'b0010);
        check("strb_fetch", {regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC}, 6'b000000);
        fetch(32'h9);
        exec1(mk(2'b01, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'b1111, 2'd0);
        check("sl0_hold", status, 4'b0010);
        check("sl0_pc", imem_addr, 64'h8);

        // fetch wait holds
        tick();
        check("wait_pc", imem_addr, 64'h8);
        check("wait_exec", exec, 1'b0);

        // runaway micro-sequence 1,2,3,1 with stray acks during EXEC
        fetch(32'h8B02_0020);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        check("ms_state0", state, 2'd0);
        exec1(mk(2'b00, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'd0, 2'd1);
        check("ms_state1", state, 2'd1);
        check("ms_ir_hold", instruction, 32'h8B02_0020);
        exec1(mk(2'b00, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'd0, 2'd2);
        check("ms_state2", state, 2'd2);
        exec1(mk(2'b00, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'd0, 2'd3);
        check("ms_state3", state, 2'd3);
        check("ms_nofault", fault, 1'b0);
        exec1(mk(2'b00, 6'd0, 1'b0, 1'b0), 64'h0, 64'h0, 4'd0, 2'd1);
        imem_ack = 1'b0;
        check("abort_fault", fault, 1'b1);
        check("abort_state", state, 2'd0);
        check("abort_pc", imem_addr, 64'hC);
        check("abort_fetch", exec, 1'b0);
        tick();
        check("fault_pulse", fault, 1'b0);

        // reset wins mid-EXEC
        fetch(32'hA);
        controlWord = mk(2'b10, 6'b100000, 1'b1, 1'b1);
        K = 64'h3000; status_in = 4'b1111; nextState = 2'd0;
        #1;
        check("pre_rst_regW", regW, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_exec_regW", regW, 1'b0);
        check("rst_exec_pc", imem_addr, 64'h0);
        check("rst_exec_req", imem_req, 1'b1);
        check("rst_exec_status", status, 4'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
